probador_compuerta: RTL

Self-test sequencer for a 2-input combinational gate such as `compuerta_and`. On a start pulse it drives all four input combinations onto the gate and holds each one for a programmable settle time. It samples the gate output for each combination, compares it against a parameterised truth table and reports a per-vector error mask plus a pass/fail result. It sits beside the gate under test and replaces hand-written stimulus in system-level checks.

---
 rtl/probador_compuerta.sv | 118 +++++++++++
 1 files changed

// File: rtl/probador_compuerta.sv
// Self-test sequencer for a 2-input gate: walks {a,b} through 00..11 and checks f against TABLA.
// Optional macro PROBADOR_ABORTO_EN: stop at the first mismatching vector.
module probador_compuerta #(
  parameter logic [3:0] TABLA  = 4'b1000,
  parameter int         ESPERA = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic [1:0] vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask
);

  typedef enum logic [1:0] {IDLE, APLICA, MUESTREA, FIN} state_t;

  // A settle time of 0 is treated as 1 so every vector is driven for at least one cycle.
  localparam int         ESP_EFF  = (ESPERA < 1) ? 1 : ESPERA;
  localparam logic [7:0] CNT_LAST = 8'(ESP_EFF - 1);

  state_t     state, state_nx;
  logic [1:0] idx, idx_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] mask_nx;
  logic       pass_nx;
  logic [1:0] ab_nx, vec_nx;
  logic       mismatch, stop_run;

  assign mismatch = (f != TABLA[idx]);

`ifdef PROBADOR_ABORTO_EN
  assign stop_run = mismatch || (idx == 2'd3);
`else
  assign stop_run = (idx == 2'd3);
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    mask_nx  = err_mask;
    pass_nx  = pass;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = APLICA;
          idx_nx   = 2'd0;
          cnt_nx   = 8'd0;
          mask_nx  = 4'd0;
          pass_nx  = 1'b0;
        end
      end
      APLICA: begin
        if (cnt == CNT_LAST) state_nx = MUESTREA;
        else                 cnt_nx   = cnt + 8'd1;
      end
      MUESTREA: begin
        if (mismatch) mask_nx[idx] = 1'b1;
        if (stop_run) begin
          state_nx = FIN;
          // pass must already reflect the mismatch captured on this closing edge.
          pass_nx  = (mask_nx == 4'd0);
        end else begin
          state_nx = APLICA;
          idx_nx   = idx + 2'd1;
          cnt_nx   = 8'd0;
        end
      end
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gate drive and vector index are registered from the next-state decode.
  always_comb begin
    ab_nx  = idx_nx;
    vec_nx = idx_nx;
    if (state_nx == IDLE) begin
      ab_nx  = 2'd0;
`ifdef PROBADOR_ABORTO_EN
      vec_nx = (mask_nx != 4'd0) ? idx_nx : 2'd0;
`else
      vec_nx = 2'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      cnt      <= 8'd0;
      err_mask <= 4'd0;
      pass     <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
      vec      <= 2'd0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      err_mask <= mask_nx;
      pass     <= pass_nx;
      a        <= ab_nx[1];
      b        <= ab_nx[0];
      vec      <= vec_nx;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule
